siren_detector: RTL

SIREN_DETECTOR -- requirements
Module: siren_detector

---
 rtl/siren_detector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/siren_detector.sv
// Two-tone siren detector: measures tone_in periods, confirms high/low tone bands and flags alternation.
// Optional build macro SIREN_DET_GLITCH_FILTER_EN adds a 2-cycle input glitch filter.

module siren_detector #(
  parameter int CNT_W   = 16,
  parameter int HI_MIN  = 80,
  parameter int HI_MAX  = 120,
  parameter int LO_MIN  = 160,
  parameter int LO_MAX  = 240,
  parameter int CONFIRM = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             tone_hi,
  output logic             tone_lo,
  output logic             siren
);

  // state | meaning
  // IDLE  | no reference edge yet
  // ARMED | one rising edge seen, no period measured
  // TRACK | periods being measured and classified
  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_HI, CLS_LO, CLS_INV} cls_t;

  localparam int CONF_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

  localparam logic [CNT_W-1:0]  HI_MIN_C  = CNT_W'(HI_MIN);
  localparam logic [CNT_W-1:0]  HI_MAX_C  = CNT_W'(HI_MAX);
  localparam logic [CNT_W-1:0]  LO_MIN_C  = CNT_W'(LO_MIN);
  localparam logic [CNT_W-1:0]  LO_MAX_C  = CNT_W'(LO_MAX);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CONF_W-1:0] CONF_MAX  = CONF_W'(CONFIRM);

  logic sync_q1, sync_q2, lvl_q, lvl_n, rise;

`ifdef SIREN_DET_GLITCH_FILTER_EN
  logic sync_q3;

  always_ff @(posedge clk) begin
    if (!rst) sync_q3 <= 1'b0;
    else      sync_q3 <= sync_q2;
  end

  // a new level is only accepted once two consecutive synchronized samples agree
  assign lvl_n = (sync_q2 == sync_q3) ? sync_q2 : lvl_q;
`else
  assign lvl_n = sync_q2;
`endif

  assign rise = lvl_n & ~lvl_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync_q1 <= tone_in;
      sync_q2 <= sync_q1;
      lvl_q   <= lvl_n;
    end
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                cnt <= '0;
    else if (rise)           cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  cls_t cls;

  always_comb begin
    cls = CLS_INV;
    if (cnt >= HI_MIN_C && cnt <= HI_MAX_C)      cls = CLS_HI;
    else if (cnt >= LO_MIN_C && cnt <= LO_MAX_C) cls = CLS_LO;
  end

  state_t           state, state_n;
  cls_t             last_cls, last_n;
  cls_t             prior, prior_n;
  logic [CONF_W-1:0] conf_cnt, conf_n, conf_step;
  logic [CNT_W-1:0] period_n;
  logic             pv_n, hi_n, lo_n, siren_n;

  always_comb begin
    conf_step = CONF_W'(1);
    if (cls == last_cls)
      conf_step = (conf_cnt == CONF_MAX) ? conf_cnt : conf_cnt + CONF_W'(1);
  end

  always_comb begin
    state_n  = state;
    period_n = period;
    pv_n     = 1'b0;
    hi_n     = tone_hi;
    lo_n     = tone_lo;
    siren_n  = siren;
    conf_n   = conf_cnt;
    last_n   = last_cls;
    prior_n  = prior;

    if (rise) begin
      if (state == IDLE) begin
        state_n = ARMED;
      end else begin
        state_n  = TRACK;
        period_n = cnt;
        pv_n     = 1'b1;
        if (cls == CLS_INV) begin
          hi_n    = 1'b0;
          lo_n    = 1'b0;
          siren_n = 1'b0;
          conf_n  = '0;
          last_n  = CLS_INV;
          prior_n = CLS_NONE;
        end else begin
          conf_n = conf_step;
          last_n = cls;
          if ((cls == CLS_HI && tone_lo) || (cls == CLS_LO && tone_hi)) begin
            hi_n = 1'b0;
            lo_n = 1'b0;
          end
          if (conf_step == CONF_MAX) begin
            hi_n    = (cls == CLS_HI);
            lo_n    = (cls == CLS_LO);
            prior_n = cls;
            // siren latches until an invalid period, timeout or reset clears it
            if (prior != CLS_NONE && prior != cls) siren_n = 1'b1;
          end
        end
      end
    end else if (state != IDLE && cnt >= TIMEOUT_C) begin
      state_n = IDLE;
      hi_n    = 1'b0;
      lo_n    = 1'b0;
      siren_n = 1'b0;
      conf_n  = '0;
      last_n  = CLS_NONE;
      prior_n = CLS_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      tone_hi      <= 1'b0;
      tone_lo      <= 1'b0;
      siren        <= 1'b0;
      conf_cnt     <= '0;
      last_cls     <= CLS_NONE;
      prior        <= CLS_NONE;
    end else begin
      state        <= state_n;
      period       <= period_n;
      period_valid <= pv_n;
      tone_hi      <= hi_n;
      tone_lo      <= lo_n;
      siren        <= siren_n;
      conf_cnt     <= conf_n;
      last_cls     <= last_n;
      prior        <= prior_n;
    end
  end

endmodule
